// File: rtl/fifo_spi_reader_pkg.sv
// Shared types and constants for the FIFO-side SPI pixel reader.
package fifo_spi_reader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } state_e;

  localparam int unsigned WORD_BITS            = 16;
  localparam int unsigned FRAME_PIXELS_DEFAULT = 2048;
  localparam int unsigned INDEX_BITS           = 11;

endpackage

// File: rtl/fifo_spi_reader_spi_sck_gen.sv
// SCK divider: CLK_DIV sys_clk cycles per half-period, low half first, idle low when disabled.
module fifo_spi_reader_spi_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt;
  logic            half_done;

  // Ticks flag the edge on which sck toggles, so users see them in the same cycle.
  assign half_done = en && (cnt == CntMax);
  assign rise_tick = half_done && !sck;
  assign fall_tick = half_done && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (half_done) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_spi_reader.sv
// SPI master draining 16-bit pixel words from the FIFO slave, with per-frame pixel indexing.
module fifo_spi_reader
  import fifo_spi_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV          = 4,
  parameter int unsigned CS_SETUP         = 2,
  parameter int unsigned CS_HOLD          = 2,
  parameter int unsigned FRAME_GAP        = 4,
  parameter int unsigned PIXELS_PER_FRAME = FRAME_PIXELS_DEFAULT
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  enable,
  input  logic                  abort,
  input  logic                  pixel_ready,
  output logic                  spi_clk,
  output logic                  fifo_cs,
  input  logic                  spi_miso,
  output logic [WORD_BITS-1:0]  pixel_data,
  output logic                  pixel_valid,
  output logic [INDEX_BITS-1:0] pixel_index,
  output logic                  frame_done,
  output logic                  busy
);

  localparam logic [15:0] SetupLast = 16'(CS_SETUP - 1);
  localparam logic [15:0] HoldLast  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GapLast   = 16'(FRAME_GAP - 1);
  localparam logic [INDEX_BITS-1:0] LastIndex = INDEX_BITS'(PIXELS_PER_FRAME - 1);

  state_e                  state;
  logic                    rdy_meta, rdy_sync;
  logic [15:0]             wait_cnt;
  logic [4:0]              bit_cnt;
  logic [WORD_BITS-1:0]    shreg;
  logic [INDEX_BITS-1:0]   pix_cnt;
  logic                    sck_en, rise_tick, fall_tick;

  // Gating with abort lets spi_clk drop on the same edge the FSM leaves SHIFT.
  assign sck_en = (state == StShift) && !abort;

  fifo_spi_reader_spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_spi_sck_gen (
    .clk      (sys_clk),
    .rst_n    (sys_rst),
    .en       (sck_en),
    .sck      (spi_clk),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rdy_meta <= 1'b0;
      rdy_sync <= 1'b0;
    end else begin
      rdy_meta <= pixel_ready;
      rdy_sync <= rdy_meta;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state       <= StIdle;
      fifo_cs     <= 1'b1;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      wait_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      pix_cnt     <= '0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (abort) begin
        pix_cnt  <= '0;
        fifo_cs  <= 1'b1;
        wait_cnt <= '0;
        if (state != StIdle) begin
          state <= StGap;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          StIdle: begin
            if (enable && rdy_sync) begin
              state    <= StSetup;
              fifo_cs  <= 1'b0;
              busy     <= 1'b1;
              wait_cnt <= '0;
            end
          end
          StSetup: begin
            if (wait_cnt == SetupLast) begin
              state    <= StShift;
              bit_cnt  <= 5'(WORD_BITS);
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          StShift: begin
            if (rise_tick) shreg <= {shreg[WORD_BITS-2:0], spi_miso};
            if (fall_tick) begin
              bit_cnt <= bit_cnt - 1'b1;
              if (bit_cnt == 5'd1) begin
                state    <= StHold;
                wait_cnt <= '0;
              end
            end
          end
          StHold: begin
            if (wait_cnt == HoldLast) begin
              state       <= StGap;
              fifo_cs     <= 1'b1;
              wait_cnt    <= '0;
              pixel_data  <= shreg;
              pixel_valid <= 1'b1;
              pixel_index <= pix_cnt;
              frame_done  <= (pix_cnt == LastIndex);
              pix_cnt     <= (pix_cnt == LastIndex) ? '0 : pix_cnt + 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          StGap: begin
            if (wait_cnt == GapLast) begin
              state    <= StIdle;
              busy     <= 1'b0;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
